// File: rtl/text_console_writer_pkg.sv
// Shared constants, state encoding and ASCII-to-glyph translation
// for the text console writer and its display-facing RAM bus.
package text_console_pkg;

    localparam int COLS   = 64;
    localparam int ROWS   = 24;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 5;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        BSP,
        SCR_RD,
        SCR_WR,
        SCR_CLR,
        CLR
    } state_t;

    // Letters of either case become glyphs 1..26; anything else is blank.
    function automatic logic [DATA_W-1:0] ascii_to_glyph(
        input logic [7:0] c
    );
        logic [DATA_W-1:0] g;
        g = '0;
        if (c >= 8'h41 && c <= 8'h5A) begin
            g = c - 8'h40;
        end else if (c >= 8'h61 && c <= 8'h7A) begin
            g = c - 8'h60;
        end
        return g;
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream handshake plus the write-capable character RAM port.
// master = console writer side, slave = producer / RAM side.
interface text_console_writer_if;
    import text_console_pkg::*;

    logic [7:0]        CHAR_DATA;
    logic              CHAR_VALID;
    logic              CHAR_READY;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_RDATA;

    modport master (
        input  CHAR_DATA,
        input  CHAR_VALID,
        output CHAR_READY,
        output MEM_ADDR,
        output MEM_WDATA,
        output MEM_WE,
        input  MEM_RDATA
    );

    modport slave (
        output CHAR_DATA,
        output CHAR_VALID,
        input  CHAR_READY,
        input  MEM_ADDR,
        input  MEM_WDATA,
        input  MEM_WE,
        output MEM_RDATA
    );

endinterface

// File: rtl/text_console_writer.sv
// Text console writer: ASCII stream -> glyph codes in the 64x24 char RAM.
// Ports: CLOCK_50, RESET, bus (char handshake + RAM), CURSOR_X/Y, BUSY.
module text_console_writer
    import text_console_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             RESET,
    text_console_writer_if.master bus,
    output logic [COL_W-1:0] CURSOR_X,
    output logic [ROW_W-1:0] CURSOR_Y,
    output logic             BUSY
);

    localparam logic [ADDR_W-1:0] LAST_SRC = ADDR_W'((ROWS-1)*COLS-1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS*COLS-1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS-1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS-1);

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        ch;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= CLR;
            idx   <= '0;
            col   <= '0;
            row   <= '0;
            ch    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CHAR_VALID) begin
                        ch <= bus.CHAR_DATA;
                        unique case (1'b1)
                            (bus.CHAR_DATA >= 8'h20): state <= WRITE;
                            (bus.CHAR_DATA == LF): begin
                                col <= '0;
                                if (row < LAST_ROW) begin
                                    row <= row + 1'b1;
                                end else begin
                                    idx   <= '0;
                                    state <= SCR_RD;
                                end
                            end
                            (bus.CHAR_DATA == CR): col <= '0;
                            (bus.CHAR_DATA == BS): state <= BSP;
                            (bus.CHAR_DATA == FF): begin
                                idx   <= '0;
                                state <= CLR;
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    if (col < LAST_COL) begin
                        col   <= col + 1'b1;
                        state <= IDLE;
                    end else begin
                        col <= '0;
                        if (row < LAST_ROW) begin
                            row   <= row + 1'b1;
                            state <= IDLE;
                        end else begin
                            idx   <= '0;
                            state <= SCR_RD;
                        end
                    end
                end
                BSP: begin
                    if (col != '0) begin
                        col <= col - 1'b1;
                    end else if (row != '0) begin
                        col <= LAST_COL;
                        row <= row - 1'b1;
                    end
                    state <= IDLE;
                end
                SCR_RD: state <= SCR_WR;
                SCR_WR: begin
                    idx <= idx + 1'b1;
                    // Past the last copy, idx lands on the first cell
                    // of the bottom row, which SCR_CLR then blanks.
                    if (idx == LAST_SRC) begin
                        state <= SCR_CLR;
                    end else begin
                        state <= SCR_RD;
                    end
                end
                SCR_CLR: begin
                    if (idx == LAST_CELL) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                CLR: begin
                    if (idx == LAST_CELL) begin
                        col   <= '0;
                        row   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= CLR;
                end
            endcase
        end
    end

    // Scroll copy: read one row down, write the RAM's answer back
    // on the following cycle.
    always_comb begin
        addr  = '0;
        wdata = '0;
        we    = 1'b0;
        case (state)
            WRITE: begin
                addr  = {row, col};
                wdata = ascii_to_glyph(ch);
                we    = 1'b1;
            end
            BSP: begin
                if (col != '0) begin
                    addr = {row, col - 1'b1};
                    we   = 1'b1;
                end else if (row != '0) begin
                    addr = {row - 1'b1, LAST_COL};
                    we   = 1'b1;
                end
            end
            SCR_RD: addr = idx + ROW_STEP;
            SCR_WR: begin
                addr  = idx;
                wdata = bus.MEM_RDATA;
                we    = 1'b1;
            end
            SCR_CLR, CLR: begin
                addr = idx;
                we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.MEM_ADDR   = addr;
    assign bus.MEM_WDATA  = wdata;
    assign bus.MEM_WE     = we;
    assign bus.CHAR_READY = (state == IDLE);
    assign BUSY = (state == SCR_RD) || (state == SCR_WR) ||
                  (state == SCR_CLR) || (state == CLR);
    assign CURSOR_X = col;
    assign CURSOR_Y = row;

endmodule
